// File: rtl/mips32_run_ctrl_pkg.sv
// mips32_pkg: shared state encoding and constants for the MIPS32 run controller.
package mips32_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, REGINIT, CLR, RUN, DONE} run_state_t;
  localparam int NUM_REGS = 32;
endpackage

// File: rtl/mips32_run_ctrl_if.sv
// mips32_run_ctrl_if: program-load handshake and MEM write bus of the run controller.
interface mips32_run_ctrl_if #(parameter int MEM_AW = 10, parameter int DATA_W = 32);
  logic ld_valid, ld_ready, ld_last, mem_we;
  logic [DATA_W-1:0] ld_data, mem_wdata;
  logic [MEM_AW-1:0] mem_addr;
  modport master (output ld_valid, ld_data, ld_last, input ld_ready, mem_we, mem_addr, mem_wdata);
  modport slave (input ld_valid, ld_data, ld_last, output ld_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/mips32_run_ctrl_watchdog.sv
// mips32_run_watchdog: saturating RUN-cycle counter with watchdog limit compare (limit 0 = off).
module mips32_run_watchdog #(parameter int W = 16) (
  input  logic         clk1,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         expire
);
  assign expire = limit != '0 && cnt + W'(1) == limit;
  always_ff @(posedge clk1 or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && !(&cnt)) cnt <= cnt + W'(1);
endmodule

// File: rtl/mips32_run_ctrl.sv
// mips32_run_ctrl: loads a program into MEM, clears and runs the core, reports halt/timeout.
// Define MIPS32_RUN_CTRL_REGINIT_EN to add a Register[i]=i init pass before the core clear.
module mips32_run_ctrl
  import mips32_pkg::*;
#(
  parameter int MEM_AW    = 10,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk1,
  input  logic                 rst,
  input  logic                 start,
  mips32_run_ctrl_if.slave     bus,
  output logic                 rf_we,
  output logic [4:0]           rf_addr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic                 core_clr,
  output logic                 core_run,
  input  logic                 core_halted,
  input  logic [TIMEOUT_W-1:0] timeout_max,
  output logic                 busy,
  output logic                 done,
  output logic                 timed_out,
  output logic [MEM_AW:0]      word_cnt,
  output logic [TIMEOUT_W-1:0] cycle_cnt
);
  run_state_t state;
  logic go, xfer, last, halt, expire;
  assign go = start && (state == IDLE || state == DONE);
  assign bus.ld_ready = state == LOAD;
  assign xfer = bus.ld_valid && bus.ld_ready;
  // the word landing in the top MEM address ends the load even without ld_last
  assign last = bus.ld_last || &word_cnt[MEM_AW-1:0];
  assign bus.mem_we = xfer;
  assign bus.mem_addr = word_cnt[MEM_AW-1:0];
  assign bus.mem_wdata = xfer ? bus.ld_data : '0;
  assign core_clr = state == CLR;
  assign core_run = state == RUN;
  assign done = state == DONE;
  assign busy = !(state == IDLE || state == DONE);
  // the core's HALTED is stale during the first RUN cycle, when the count is still 0
  assign halt = core_run && cycle_cnt != '0 && core_halted;
`ifdef MIPS32_RUN_CTRL_REGINIT_EN
  localparam run_state_t NEXT_LOAD = REGINIT;
  logic [4:0] ri;
  assign rf_we = state == REGINIT;
  assign rf_addr = ri;
  assign rf_wdata = DATA_W'(ri);
`else
  localparam run_state_t NEXT_LOAD = CLR;
  assign rf_we = 1'b0;
  assign rf_addr = '0;
  assign rf_wdata = '0;
`endif
  mips32_run_watchdog #(.W(TIMEOUT_W)) u_wd (
    .clk1(clk1), .rst(rst), .clr(go || core_clr), .en(core_run),
    .limit(timeout_max), .cnt(cycle_cnt), .expire(expire)
  );
  always_ff @(posedge clk1 or posedge rst)
    if (rst) begin
      state <= IDLE;
      word_cnt <= '0;
      timed_out <= 1'b0;
`ifdef MIPS32_RUN_CTRL_REGINIT_EN
      ri <= '0;
`endif
    end else case (state)
      IDLE, DONE: if (start) begin
        state <= LOAD;
        word_cnt <= '0;
        timed_out <= 1'b0;
      end
      LOAD: if (xfer) begin
        word_cnt <= word_cnt + (MEM_AW+1)'(1);
        if (last) state <= NEXT_LOAD;
      end
`ifdef MIPS32_RUN_CTRL_REGINIT_EN
      REGINIT: begin
        ri <= ri + 5'd1;
        if (ri == 5'(NUM_REGS-1)) state <= CLR;
      end
`endif
      CLR: state <= RUN;
      RUN: if (halt) state <= DONE;
        else if (expire) begin
          state <= DONE;
          timed_out <= 1'b1;
        end
      default: state <= IDLE;
    endcase
endmodule

// File: tb/tb_mips32_run_ctrl.sv
// tb_mips32_run_ctrl: randomized load/run sessions checked against a session-level reference model.
module tb_mips32_run_ctrl;
  localparam int AW = 4, DW = 32, TW = 16, CAP = 1 << AW;
`ifdef MIPS32_RUN_CTRL_REGINIT_EN
  localparam int LAT = 33, NRF = 32;
`else
  localparam int LAT = 1, NRF = 0;
`endif
  logic clk1 = 1'b0, rst = 1'b1, start = 1'b0, core_halted = 1'b0;
  logic rf_we, core_clr, core_run, busy, done, timed_out;
  logic [4:0] rf_addr;
  logic [DW-1:0] rf_wdata;
  logic [TW-1:0] timeout_max = '0, cycle_cnt;
  logic [AW:0] word_cnt;
  int n_chk = 0, n_fail = 0, halt_at = 0;

  mips32_run_ctrl_if #(.MEM_AW(AW), .DATA_W(DW)) bus ();
  mips32_run_ctrl #(.MEM_AW(AW), .DATA_W(DW), .TIMEOUT_W(TW)) dut (
    .clk1(clk1), .rst(rst), .start(start), .bus(bus),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
    .core_clr(core_clr), .core_run(core_run), .core_halted(core_halted),
    .timeout_max(timeout_max), .busy(busy), .done(done), .timed_out(timed_out),
    .word_cnt(word_cnt), .cycle_cnt(cycle_cnt)
  );

  always #5 clk1 = ~clk1;

  // mid-cycle monitor: logs every MEM write, rf write, clear pulse and RUN cycle
  int cyc = 0, run_n = 0;
  logic [31:0] wr_a[$], wr_d[$], rf_a[$], rf_d[$];
  int wr_c[$], rf_c[$], clr_c[$];
  initial forever begin
    @(negedge clk1);
    cyc++;
    if (bus.mem_we === 1'b1) begin
      wr_a.push_back(32'(bus.mem_addr)); wr_d.push_back(bus.mem_wdata); wr_c.push_back(cyc);
    end
    if (rf_we === 1'b1) begin
      rf_a.push_back(32'(rf_addr)); rf_d.push_back(rf_wdata); rf_c.push_back(cyc);
    end
    if (core_clr === 1'b1) clr_c.push_back(cyc);
    if (core_run === 1'b1) run_n++;
  end

  // core stand-in: HALTED rises in RUN cycle halt_at (0 = never) and is cleared by core_clr
  initial begin
    int run_seen = 0;
    forever begin
      @(posedge clk1); #1;
      if (core_clr) run_seen = 0;
      if (core_run) run_seen++;
      core_halted = halt_at != 0 && core_run && run_seen >= halt_at;
    end
  end

  initial begin #3000000; $display("FAIL global_timeout"); $fatal(1, "bench timeout"); end

  task automatic tick; @(posedge clk1); #1; endtask

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return {bus.ld_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, rf_we, rf_addr, rf_wdata,
            core_clr, core_run, busy, done, timed_out, word_cnt, cycle_cnt};
  endfunction

  // mode: 0 ld_valid always high, 1 pattern 1-0-0-1, 2 random
  task automatic session(input int n, input bit use_last, input int mode, input int h,
                         input int tmax, input bit poke);
    logic [31:0] words[$];
    int wb, rb, cb, rn0, k, idle, exp_n, eh, et, exp_c;
    bit exp_to;
    for (int i = 0; i < n; i++) words.push_back($urandom);
    exp_n = n < CAP ? n : CAP;
    eh = h == 0 ? 1 << 30 : (h < 2 ? 2 : h);
    et = tmax == 0 ? 1 << 30 : tmax;
    exp_c = eh <= et ? eh : et;
    exp_to = et < eh;
    halt_at = h;
    timeout_max = TW'(tmax);
    wb = wr_a.size(); rb = rf_a.size(); cb = clr_c.size(); rn0 = run_n;
    start = 1'b1; tick; start = 1'b0;
    check("start_busy", busy, 1);
    check("start_clears", {done, timed_out, word_cnt, cycle_cnt}, 0);
    k = 0; idle = 0;
    for (int c = 0; c < 400 && k < n && idle < 4; c++) begin
      bus.ld_valid = mode == 0 ? 1'b1 : mode == 1 ? (c % 4 == 0 || c % 4 == 3) : 1'($urandom_range(0, 1));
      bus.ld_data = words[k];
      bus.ld_last = use_last && k == n - 1;
      @(negedge clk1);
      if (bus.ld_valid && bus.ld_ready) k++;
      else if (!bus.ld_ready) idle++;
      tick;
    end
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
    check("words_accepted", k, exp_n);
    if (poke) begin
      for (int c = 0; c < 100 && !core_run; c++) tick;
      start = 1'b1; tick; start = 1'b0;
      check("start_in_run_ignored", {busy, core_run, word_cnt}, {2'b11, (AW+1)'(exp_n)});
    end
    for (int c = 0; c < 3000 && !done; c++) tick;
    check("done", done, 1);
    check("timed_out", timed_out, exp_to);
    check("cycle_cnt", cycle_cnt, exp_c);
    check("word_cnt", word_cnt, exp_n);
    check("idle_after_done", {busy, core_run, core_clr}, 0);
    check("run_cycles", run_n - rn0, exp_c);
    check("mem_writes", wr_a.size() - wb, exp_n);
    for (int i = 0; i < exp_n && wb + i < wr_a.size(); i++) begin
      check("mem_addr", wr_a[wb+i], i);
      check("mem_wdata", wr_d[wb+i], words[i]);
    end
    check("clr_pulses", clr_c.size() - cb, 1);
    if (clr_c.size() > cb && wr_a.size() >= wb + exp_n)
      check("clr_latency", clr_c[cb] - wr_c[wb+exp_n-1], LAT);
    check("rf_writes", rf_a.size() - rb, NRF);
    for (int i = 0; i < rf_a.size() - rb && i < 32; i++) begin
      check("rf_addr", rf_a[rb+i], i);
      check("rf_wdata", rf_d[rb+i], i);
    end
    if (rf_a.size() > rb && clr_c.size() > cb)
      check("rf_before_clr", clr_c[cb] - rf_c[rf_a.size()-1], 1);
  endtask

  initial begin
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0; bus.ld_data = '0;
    tick; tick;
    @(negedge clk1);
    check("reset_outputs", all_outs(), 0);
    tick; rst = 1'b0; tick;
    session(14, 1'b1, 0, 20, 0, 1'b0);
    session(9, 1'b1, 1, 30, 0, 1'b0);
    session(6, 1'b1, 0, 0, 50, 1'b0);
    session(20, 1'b0, 0, 15, 0, 1'b0);
    session(8, 1'b1, 2, 40, 0, 1'b1);
    session(5, 1'b1, 0, 25, 25, 1'b0);
    session(3, 1'b1, 0, 1, 0, 1'b0);
    session(CAP, 1'b1, 0, 0, 1, 1'b0);
    for (int r = 0; r < 6; r++) begin
      int n, h, t;
      bit ul;
      ul = 1'($urandom_range(0, 1));
      n = ul ? $urandom_range(1, CAP + 4) : $urandom_range(CAP, CAP + 4);
      h = $urandom_range(0, 60);
      t = $urandom_range(0, 60);
      if (h == 0 && t == 0) h = 10;
      session(n, ul, $urandom_range(0, 2), h, t, 1'b0);
    end
    // reset in the middle of a load, then a fresh session restarts at address 0
    start = 1'b1; tick; start = 1'b0;
    bus.ld_valid = 1'b1; bus.ld_data = 32'hDEAD_BEEF;
    tick; tick; tick;
    check("load_progress", word_cnt, 3);
    rst = 1'b1;
    @(negedge clk1);
    check("mid_load_reset_outputs", all_outs(), 0);
    bus.ld_valid = 1'b0;
    tick; rst = 1'b0; tick;
    session(4, 1'b1, 0, 10, 0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
